// File: rtl/mmio_arbiter_2m.sv
// Two-master round-robin arbiter in front of a single MMIO slave port.
// One arbitration cycle, then slave latency (bounded by TIMEOUT); stalled masters simply hold req.
module mmio_arbiter_2m #(
  parameter int ADDR_W = 32,
  parameter int XLEN = 32,
  parameter int TIMEOUT = 16,
  parameter logic [XLEN-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [XLEN-1:0]   m0_wdata,
  output logic [XLEN-1:0]   m0_rdata,
  output logic              m0_ready,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [XLEN-1:0]   m1_wdata,
  output logic [XLEN-1:0]   m1_rdata,
  output logic              m1_ready,
  output logic              slave_req,
  output logic              slave_we,
  output logic [ADDR_W-1:0] slave_addr,
  output logic [XLEN-1:0]   slave_wdata,
  input  logic [XLEN-1:0]   slave_rdata,
  input  logic              slave_ready,
  output logic              grant,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic {IDLE, XFER} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t          state, state_n;
  logic            prio, prio_n;
  logic            grant_n;
  logic            terr_n;
  logic [7:0]      cnt, cnt_n;
  logic [XLEN-1:0] done_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      prio        <= 1'b0;
      grant       <= 1'b0;
      cnt         <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      prio        <= prio_n;
      grant       <= grant_n;
      cnt         <= cnt_n;
      timeout_err <= terr_n;
    end
  end

  assign busy = (state == XFER);

  always_comb begin
    state_n     = state;
    prio_n      = prio;
    grant_n     = grant;
    cnt_n       = cnt;
    terr_n      = timeout_err;
    slave_req   = 1'b0;
    slave_we    = 1'b0;
    slave_addr  = '0;
    slave_wdata = '0;
    m0_ready    = 1'b0;
    m1_ready    = 1'b0;
    m0_rdata    = '0;
    m1_rdata    = '0;
    done_data   = '0;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_n = XFER;
          cnt_n   = 8'd0;
          grant_n = (m0_req && m1_req) ? prio : m1_req;
        end
      end
      XFER: begin
        slave_req   = 1'b1;
        slave_we    = grant ? m1_we    : m0_we;
        slave_addr  = grant ? m1_addr  : m0_addr;
        slave_wdata = grant ? m1_wdata : m0_wdata;
        if (slave_ready || cnt == CNT_LAST) begin
          // A timed-out read gets the error pattern; a timed-out write just completes.
          if (slave_ready)   done_data = slave_rdata;
          else if (!slave_we) done_data = ERR_DATA;
          if (grant) begin
            m1_ready = 1'b1;
            m1_rdata = done_data;
          end else begin
            m0_ready = 1'b1;
            m0_rdata = done_data;
          end
          state_n = IDLE;
          prio_n  = ~grant;
          if (!slave_ready) terr_n = 1'b1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
